signal_gen_lpf: RTL and testbench

- Self-contained stimulus-and-filter block. A waveform generator produces three test signals: x1 triangle, x2 sawtooth, x3 square.
- Each signal feeds its own identical 8-tap integer FIR low-pass channel.
- Used as the signal-conditioning demo/reference datapath. x1 and x2 are fixed-point in tenths of a unit (value/10 = integer part, value%10 = tenths); x3 is a plain integer.

---
 rtl/signal_gen_lpf_pkg.sv | 31 +++
 rtl/signal_gen_lpf_if.sv | 25 ++
 rtl/signal_gen_lpf_lpf_channel.sv | 51 +++++
 rtl/signal_gen_lpf.sv | 159 +++++++++++++++
 tb/tb_signal_gen_lpf.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/signal_gen_lpf_pkg.sv
// ---------------------------------------------------------------------------
// signal_gen_lpf_pkg
// Shared constants and types for the signal generator / low-pass filter block.
//   TAPS      : number of FIR taps per channel
//   SAMPLE_W  : width of a filter input sample (and of each delay-line stage)
//   ACC_W     : width of the filter accumulator / output
//   COEF      : FIR coefficients, symmetric low-pass window with DC gain 20
//   dir_t     : triangle generator direction
// ---------------------------------------------------------------------------
package signal_gen_lpf_pkg;

   localparam int TAPS     = 8;
   localparam int SAMPLE_W = 12;
   localparam int ACC_W    = 24;

   typedef logic [SAMPLE_W-1:0] sample_t;
   typedef logic [ACC_W-1:0]    acc_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   localparam int unsigned COEF [TAPS] = '{1, 2, 3, 4, 4, 3, 2, 1};

   // Coefficient k widened to accumulator width so products never truncate.
   function automatic acc_t coefAt(input int k);
      return acc_t'(COEF[k]);
   endfunction

endpackage

// File: rtl/signal_gen_lpf_if.sv
// ---------------------------------------------------------------------------
// signal_gen_lpf_if
// Bundles the generator samples and the filtered outputs of signal_gen_lpf.
//   x1 : triangle sample, tenths of a unit (12 bits)
//   x2 : sawtooth sample, tenths of a unit (12 bits)
//   x3 : square sample, integer (8 bits)
//   y1 : filtered x1 (24 bits)
//   y2 : filtered x2 (24 bits)
//   y3 : filtered x3 (24 bits)
// master drives all of them (the block), slave observes them.
// ---------------------------------------------------------------------------
interface signal_gen_lpf_if;
   import signal_gen_lpf_pkg::*;

   logic [11:0] x1;
   logic [11:0] x2;
   logic [7:0]  x3;
   acc_t        y1;
   acc_t        y2;
   acc_t        y3;

   modport master (output x1, output x2, output x3, output y1, output y2, output y3);
   modport slave  (input  x1, input  x2, input  x3, input  y1, input  y2, input  y3);

endinterface

// File: rtl/signal_gen_lpf_lpf_channel.sv
// ---------------------------------------------------------------------------
// lpf_channel
// One 8-tap unsigned integer FIR low-pass channel.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   i_x  : input sample, sampled every clock
//   o_y  : registered filter output, sum of coef[k]*d[k] over the pre-edge
//          delay line, so a sample taken at edge E first shows at edge E+1
// ---------------------------------------------------------------------------
module lpf_channel
   import signal_gen_lpf_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  sample_t i_x,
   output acc_t    o_y
);

   sample_t r_d [TAPS];
   acc_t    r_y;
   acc_t    w_sum;

   // Weighted sum of the current delay line. The worst case 4095*20 fits in
   // the accumulator, so no saturation logic is needed.
   always_comb begin
      w_sum = '0;
      for (int k = 0; k < TAPS; k++) begin
         w_sum = w_sum + acc_t'(r_d[k]) * coefAt(k);
      end
   end

   // Delay line shifts every clock and the output captures the sum of the
   // values that were in the line just before this edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < TAPS; k++) begin
            r_d[k] <= '0;
         end
         r_y <= '0;
      end else begin
         r_d[0] <= i_x;
         for (int k = 1; k < TAPS; k++) begin
            r_d[k] <= r_d[k-1];
         end
         r_y <= w_sum;
      end
   end

   assign o_y = r_y;

endmodule

// File: rtl/signal_gen_lpf.sv
// ---------------------------------------------------------------------------
// signal_gen_lpf
// Waveform generator (triangle, sawtooth, square) feeding three identical
// FIR low-pass channels. Generators advance once per prescaler tick; filters
// run every clock.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : master side of signal_gen_lpf_if (x1/x2/x3 samples, y1/y2/y3
//          filtered outputs)
// ---------------------------------------------------------------------------
module signal_gen_lpf
   import signal_gen_lpf_pkg::*;
#(
   parameter int DIV     = 100,
   parameter int X1_MAX  = 1000,
   parameter int X1_STEP = 10,
   parameter int X2_MAX  = 2000,
   parameter int X2_STEP = 25,
   parameter int X3_HIGH = 200,
   parameter int X3_HALF = 25
)
(
   input  logic             clk,
   input  logic             rst,
   signal_gen_lpf_if.master bus
);

   localparam int PRESC_W = ($clog2(DIV) > 0) ? $clog2(DIV) : 1;
   localparam int SQ_W    = ($clog2(X3_HALF) > 0) ? $clog2(X3_HALF) : 1;

   logic [PRESC_W-1:0] r_prescCount;
   logic               w_tick;

   sample_t            r_x1;
   dir_t               r_dir;
   sample_t            r_x2;
   logic [7:0]         r_x3;
   logic [SQ_W-1:0]    r_sqCount;

   sample_t            w_x1Next;
   dir_t               w_dirNext;
   sample_t            w_x2Next;
   logic [7:0]         w_x3Next;
   logic [SQ_W-1:0]    w_sqNext;

   logic [SAMPLE_W:0]  w_x1Up;
   logic [SAMPLE_W:0]  w_x2Up;

   acc_t               w_y1;
   acc_t               w_y2;
   acc_t               w_y3;

   // Prescaler: free-running 0..DIV-1; the tick is the cycle that ends a
   // full count, so the first generator update lands on edge DIV.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prescCount <= '0;
      end else if (w_tick) begin
         r_prescCount <= '0;
      end else begin
         r_prescCount <= r_prescCount + 1'b1;
      end
   end

   assign w_tick = (r_prescCount == PRESC_W'(DIV - 1));

   // One extra bit so the candidate sums can be compared against the peak
   // without wrapping.
   assign w_x1Up = {1'b0, r_x1} + (SAMPLE_W+1)'(X1_STEP);
   assign w_x2Up = {1'b0, r_x2} + (SAMPLE_W+1)'(X2_STEP);

   // Next-value logic for all three generators. The triangle clamps to its
   // limits and flips direction there so it never overshoots; the sawtooth
   // drops to zero when the next step would pass its peak; the square
   // toggles each time its half-period counter wraps.
   always_comb begin
      w_x1Next  = r_x1;
      w_dirNext = r_dir;
      w_x2Next  = r_x2;
      w_x3Next  = r_x3;
      w_sqNext  = r_sqCount;

      if (r_dir == DIR_UP) begin
         if (w_x1Up >= (SAMPLE_W+1)'(X1_MAX)) begin
            w_x1Next  = SAMPLE_W'(X1_MAX);
            w_dirNext = DIR_DOWN;
         end else begin
            w_x1Next = w_x1Up[SAMPLE_W-1:0];
         end
      end else begin
         if (r_x1 <= SAMPLE_W'(X1_STEP)) begin
            w_x1Next  = '0;
            w_dirNext = DIR_UP;
         end else begin
            w_x1Next = r_x1 - SAMPLE_W'(X1_STEP);
         end
      end

      if (w_x2Up > (SAMPLE_W+1)'(X2_MAX)) begin
         w_x2Next = '0;
      end else begin
         w_x2Next = w_x2Up[SAMPLE_W-1:0];
      end

      if (r_sqCount == SQ_W'(X3_HALF - 1)) begin
         w_sqNext = '0;
         w_x3Next = (r_x3 == 8'd0) ? 8'(X3_HIGH) : 8'd0;
      end else begin
         w_sqNext = r_sqCount + 1'b1;
      end
   end

   // Generator state only moves on a tick; between ticks every sample holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_x1      <= '0;
         r_dir     <= DIR_UP;
         r_x2      <= '0;
         r_x3      <= '0;
         r_sqCount <= '0;
      end else if (w_tick) begin
         r_x1      <= w_x1Next;
         r_dir     <= w_dirNext;
         r_x2      <= w_x2Next;
         r_x3      <= w_x3Next;
         r_sqCount <= w_sqNext;
      end
   end

   lpf_channel u_lpf1 (
      .clk (clk),
      .rst (rst),
      .i_x (r_x1),
      .o_y (w_y1)
   );

   lpf_channel u_lpf2 (
      .clk (clk),
      .rst (rst),
      .i_x (r_x2),
      .o_y (w_y2)
   );

   // The square wave is only 8 bits; the filter sees it zero-extended.
   lpf_channel u_lpf3 (
      .clk (clk),
      .rst (rst),
      .i_x ({4'd0, r_x3}),
      .o_y (w_y3)
   );

   assign bus.x1 = r_x1;
   assign bus.x2 = r_x2;
   assign bus.x3 = r_x3;
   assign bus.y1 = w_y1;
   assign bus.y2 = w_y2;
   assign bus.y3 = w_y3;

endmodule

// File: tb/tb_signal_gen_lpf.sv
// ---------------------------------------------------------------------------
// tb_signal_gen_lpf
// Self-checking bench for signal_gen_lpf plus a standalone lpf_channel used
// to drive arbitrary filter inputs (step, impulse, full-scale).
// ---------------------------------------------------------------------------
module tb_signal_gen_lpf;
   import signal_gen_lpf_pkg::*;

   typedef struct {
      logic [11:0] x;
      logic [23:0] y;
   } firVec_t;

   logic    clk;
   logic    rst;
   logic    rstF;
   sample_t fx;
   acc_t    fy;

   int      vecCount;
   int      missCount;
   int      edgeCount;

   firVec_t tbl [39];

   signal_gen_lpf_if bus ();

   signal_gen_lpf dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   lpf_channel fir (
      .clk (clk),
      .rst (rstF),
      .i_x (fx),
      .o_y (fy)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [11:0] x);
      fx = x;
   endtask

   // Advance to a given rising edge after the top's reset release, then
   // settle 1 time unit past it before any sampling.
   task automatic gotoEdge(input int target);
      while (edgeCount < target) begin
         @(posedge clk);
         edgeCount++;
      end
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " x1"}, 32'(bus.x1), 32'd0);
      checkOutput({tag, " x2"}, 32'(bus.x2), 32'd0);
      checkOutput({tag, " x3"}, 32'(bus.x3), 32'd0);
      checkOutput({tag, " y1"}, 32'(bus.y1), 32'd0);
      checkOutput({tag, " y2"}, 32'(bus.y2), 32'd0);
      checkOutput({tag, " y3"}, 32'(bus.y3), 32'd0);
   endtask

   // Post-release startup: nothing moves until edge 100, then the y1 of the
   // first sample shows two edges later.
   task automatic checkStartup(input string tag);
      gotoEdge(99);
      checkOutput({tag, " x1@99"}, 32'(bus.x1), 32'd0);
      checkOutput({tag, " x2@99"}, 32'(bus.x2), 32'd0);
      gotoEdge(100);
      checkOutput({tag, " x1@100"}, 32'(bus.x1), 32'd10);
      checkOutput({tag, " x2@100"}, 32'(bus.x2), 32'd25);
      checkOutput({tag, " x3@100"}, 32'(bus.x3), 32'd0);
      checkOutput({tag, " y1@100"}, 32'(bus.y1), 32'd0);
      gotoEdge(101);
      checkOutput({tag, " y1@101"}, 32'(bus.y1), 32'd0);
      gotoEdge(102);
      checkOutput({tag, " y1@102"}, 32'(bus.y1), 32'd10);
      checkOutput({tag, " y2@102"}, 32'(bus.y2), 32'd25);
   endtask

   initial begin
      vecCount  = 0;
      missCount = 0;
      edgeCount = 0;
      rst       = 1'b0;
      rstF      = 1'b0;
      fx        = '0;

      // Step of 100, drain to zero, unit impulse, then full-scale step.
      // Entry i: input driven before edge i, output expected just after it.
      tbl[0]  = '{12'd100,  24'd0};
      tbl[1]  = '{12'd100,  24'd100};
      tbl[2]  = '{12'd100,  24'd300};
      tbl[3]  = '{12'd100,  24'd600};
      tbl[4]  = '{12'd100,  24'd1000};
      tbl[5]  = '{12'd100,  24'd1400};
      tbl[6]  = '{12'd100,  24'd1700};
      tbl[7]  = '{12'd100,  24'd1900};
      tbl[8]  = '{12'd100,  24'd2000};
      tbl[9]  = '{12'd100,  24'd2000};
      tbl[10] = '{12'd0,    24'd2000};
      tbl[11] = '{12'd0,    24'd1900};
      tbl[12] = '{12'd0,    24'd1700};
      tbl[13] = '{12'd0,    24'd1400};
      tbl[14] = '{12'd0,    24'd1000};
      tbl[15] = '{12'd0,    24'd600};
      tbl[16] = '{12'd0,    24'd300};
      tbl[17] = '{12'd0,    24'd100};
      tbl[18] = '{12'd0,    24'd0};
      tbl[19] = '{12'd1,    24'd0};
      tbl[20] = '{12'd0,    24'd1};
      tbl[21] = '{12'd0,    24'd2};
      tbl[22] = '{12'd0,    24'd3};
      tbl[23] = '{12'd0,    24'd4};
      tbl[24] = '{12'd0,    24'd4};
      tbl[25] = '{12'd0,    24'd3};
      tbl[26] = '{12'd0,    24'd2};
      tbl[27] = '{12'd0,    24'd1};
      tbl[28] = '{12'd0,    24'd0};
      tbl[29] = '{12'd4095, 24'd0};
      tbl[30] = '{12'd4095, 24'd4095};
      tbl[31] = '{12'd4095, 24'd12285};
      tbl[32] = '{12'd4095, 24'd24570};
      tbl[33] = '{12'd4095, 24'd40950};
      tbl[34] = '{12'd4095, 24'd57330};
      tbl[35] = '{12'd4095, 24'd69615};
      tbl[36] = '{12'd4095, 24'd77805};
      tbl[37] = '{12'd4095, 24'd81900};
      tbl[38] = '{12'd4095, 24'd81900};

      $display("[TB] standalone filter vectors");
      repeat (3) @(negedge clk);
      checkOutput("fir reset y", 32'(fy), 32'd0);
      rstF = 1'b1;
      for (int i = 0; i < 39; i++) begin
         applyStimulus(tbl[i].x);
         @(negedge clk);
         checkOutput($sformatf("fir vec %0d", i), 32'(fy), 32'(tbl[i].y));
      end

      $display("[TB] top-level reset and startup");
      checkAllZero("reset held");
      rst = 1'b1;
      edgeCount = 0;
      checkStartup("startup");
      gotoEdge(103);
      checkOutput("y1@103", 32'(bus.y1), 32'd30);

      $display("[TB] square rise and settle");
      gotoEdge(2499);
      checkOutput("x3 tick24", 32'(bus.x3), 32'd0);
      gotoEdge(2500);
      checkOutput("x3 tick25", 32'(bus.x3), 32'd200);
      checkOutput("x1 tick25", 32'(bus.x1), 32'd250);
      checkOutput("x2 tick25", 32'(bus.x2), 32'd625);
      gotoEdge(2510);
      checkOutput("y3 settled", 32'(bus.y3), 32'd4000);
      checkOutput("y1 settled", 32'(bus.y1), 32'd5000);
      gotoEdge(5000);
      checkOutput("x3 tick50", 32'(bus.x3), 32'd0);

      $display("[TB] sawtooth wrap");
      gotoEdge(8000);
      checkOutput("x2 tick80", 32'(bus.x2), 32'd2000);
      gotoEdge(8100);
      checkOutput("x2 tick81", 32'(bus.x2), 32'd0);

      $display("[TB] triangle turnarounds");
      gotoEdge(10000);
      checkOutput("x1 tick100", 32'(bus.x1), 32'd1000);
      gotoEdge(10100);
      checkOutput("x1 tick101", 32'(bus.x1), 32'd990);
      gotoEdge(20000);
      checkOutput("x1 tick200", 32'(bus.x1), 32'd0);
      gotoEdge(20100);
      checkOutput("x1 tick201", 32'(bus.x1), 32'd10);
      checkOutput("x2 tick201", 32'(bus.x2), 32'd975);

      $display("[TB] asynchronous reset mid-ramp");
      gotoEdge(20150);
      #2;
      rst = 1'b0;
      #1;
      checkAllZero("async reset");
      @(negedge clk);
      rst = 1'b1;
      edgeCount = 0;
      checkStartup("restart");

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
